// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared op codes, FSM states and signedness helpers for mult_seq_rv
package mult_pkg;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } MUL_OP_T;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } MULT_STATE_T;

  function automatic logic is_signed_a(MUL_OP_T op);
    return op != OP_MULHU;
  endfunction

  function automatic logic is_signed_b(MUL_OP_T op);
    return (op == OP_MUL) || (op == OP_MULH);
  endfunction

endpackage

// File: rtl/mult_seq_rv_if.sv
// rtl/mult_seq_rv_if.sv - request/response bundle between the execute stage and mult_seq_rv
interface mult_seq_rv_if
  import mult_pkg::*;
#(
  parameter int N = 32
);
  logic           start;
  logic           abort;
  MUL_OP_T        op;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           busy;
  logic           done;
  logic [N-1:0]   result;
  logic [2*N-1:0] product;

  modport master (
    output start, abort, op, a, b,
    input  busy, done, result, product
  );

  modport slave (
    input  start, abort, op, a, b,
    output busy, done, result, product
  );
endinterface

// File: rtl/mult_digit_step.sv
// rtl/mult_digit_step.sv - one radix-2^DIG step: |a| * digit shifted into the 2N-bit accumulator
module mult_digit_step #(
  parameter int N   = 32,
  parameter int DIG = 4,
  parameter int IW  = 4
) (
  input  logic [2*N-1:0] acc_in,
  input  logic [N-1:0]   a_mag,
  input  logic [DIG-1:0] digit,
  input  logic [IW-1:0]  iter,
  output logic [2*N-1:0] acc_out
);
  localparam int SW = $clog2(2 * N);

  logic [N+DIG-1:0] pp;
  logic [2*N-1:0]   pp_ext;
  logic [SW-1:0]    shamt;

  assign pp      = {{DIG{1'b0}}, a_mag} * {{N{1'b0}}, digit};
  assign pp_ext  = {{(N - DIG){1'b0}}, pp};
  assign shamt   = SW'(iter) * SW'(DIG);
  assign acc_out = acc_in + (pp_ext << shamt);
endmodule

// File: rtl/mult_seq_rv.sv
// rtl/mult_seq_rv.sv - iterative N x N RV32M multiplier retiring DIG multiplier bits per cycle
module mult_seq_rv
  import mult_pkg::*;
#(
  parameter int N          = 32,
  parameter int DIG        = 4,
  parameter int EARLY_TERM = 1
) (
  input logic          clk_in,
  input logic          reset_in,
  mult_seq_rv_if.slave bus
);
  localparam int ITERS = N / DIG;
  localparam int IW    = $clog2(ITERS + 1);

  MULT_STATE_T    state;
  MUL_OP_T        op_q;
  logic [N-1:0]   a_mag;
  logic [N-1:0]   mb;
  logic           neg;
  logic [2*N-1:0] acc;
  logic [IW-1:0]  iter;
  logic           busy_q;
  logic           done_q;
  logic [N-1:0]   result_q;
  logic [2*N-1:0] product_q;

  logic           sgn_a;
  logic           sgn_b;
  logic [N-1:0]   a_abs;
  logic [N-1:0]   b_abs;
  logic [N-1:0]   mb_nxt;
  logic [2*N-1:0] acc_nxt;
  logic [2*N-1:0] prod_fin;
  logic           last_step;

  mult_digit_step #(
    .N   (N),
    .DIG (DIG),
    .IW  (IW)
  ) u_step (
    .acc_in  (acc),
    .a_mag   (a_mag),
    .digit   (mb[DIG-1:0]),
    .iter    (iter),
    .acc_out (acc_nxt)
  );

  // Negating -2^(N-1) in N bits leaves the same bit pattern, which read unsigned is 2^(N-1).
  always_comb begin
    sgn_a     = is_signed_a(bus.op) & bus.a[N-1];
    sgn_b     = is_signed_b(bus.op) & bus.b[N-1];
    a_abs     = sgn_a ? -bus.a : bus.a;
    b_abs     = sgn_b ? -bus.b : bus.b;
    mb_nxt    = mb >> DIG;
    last_step = ((EARLY_TERM != 0) && (mb_nxt == '0)) || (iter == IW'(ITERS - 1));
    prod_fin  = neg ? -acc_nxt : acc_nxt;
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state     <= IDLE;
      op_q      <= OP_MUL;
      a_mag     <= '0;
      mb        <= '0;
      neg       <= 1'b0;
      acc       <= '0;
      iter      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      product_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start && !bus.abort) begin
            op_q   <= bus.op;
            a_mag  <= a_abs;
            mb     <= b_abs;
            neg    <= sgn_a ^ sgn_b;
            acc    <= '0;
            iter   <= '0;
            busy_q <= 1'b1;
            if ((a_abs == '0) || (b_abs == '0)) begin
              state     <= DONE;
              done_q    <= 1'b1;
              product_q <= '0;
              result_q  <= '0;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (bus.abort) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            acc  <= acc_nxt;
            mb   <= mb_nxt;
            iter <= iter + IW'(1);
            if (last_step) begin
              state     <= DONE;
              done_q    <= 1'b1;
              product_q <= prod_fin;
              result_q  <= (op_q == OP_MUL) ? prod_fin[N-1:0] : prod_fin[2*N-1:N];
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.result  = result_q;
  assign bus.product = product_q;
endmodule

// File: tb/tb_mult_seq_rv.sv
// tb/tb_mult_seq_rv.sv - randomized and directed checks of mult_seq_rv against an arithmetic model
module tb_mult_seq_rv;
  import mult_pkg::*;

  localparam int NI = 5;

  logic        clk_in;
  logic        reset_in;
  logic        start;
  logic        abort;
  MUL_OP_T     op;
  logic [31:0] a;
  logic [31:0] b;

  int n_checks = 0;
  int n_errors = 0;
  int hist [0:9];

  // instance 0 is the default build; the others cover other digit widths and no early exit
  int dig_p [NI] = '{4, 1, 2, 8, 4};
  bit et_p  [NI] = '{1, 1, 1, 1, 0};

  mult_seq_rv_if #(.N(32)) if0 ();
  mult_seq_rv_if #(.N(32)) if1 ();
  mult_seq_rv_if #(.N(32)) if2 ();
  mult_seq_rv_if #(.N(32)) if3 ();
  mult_seq_rv_if #(.N(32)) if4 ();

  assign if0.start = start; assign if0.abort = abort; assign if0.op = op; assign if0.a = a; assign if0.b = b;
  assign if1.start = start; assign if1.abort = abort; assign if1.op = op; assign if1.a = a; assign if1.b = b;
  assign if2.start = start; assign if2.abort = abort; assign if2.op = op; assign if2.a = a; assign if2.b = b;
  assign if3.start = start; assign if3.abort = abort; assign if3.op = op; assign if3.a = a; assign if3.b = b;
  assign if4.start = start; assign if4.abort = abort; assign if4.op = op; assign if4.a = a; assign if4.b = b;

  mult_seq_rv #(.N(32), .DIG(4), .EARLY_TERM(1)) dut0 (.clk_in(clk_in), .reset_in(reset_in), .bus(if0));
  mult_seq_rv #(.N(32), .DIG(1), .EARLY_TERM(1)) dut1 (.clk_in(clk_in), .reset_in(reset_in), .bus(if1));
  mult_seq_rv #(.N(32), .DIG(2), .EARLY_TERM(1)) dut2 (.clk_in(clk_in), .reset_in(reset_in), .bus(if2));
  mult_seq_rv #(.N(32), .DIG(8), .EARLY_TERM(1)) dut3 (.clk_in(clk_in), .reset_in(reset_in), .bus(if3));
  mult_seq_rv #(.N(32), .DIG(4), .EARLY_TERM(0)) dut4 (.clk_in(clk_in), .reset_in(reset_in), .bus(if4));

  logic        busy_v [NI];
  logic        done_v [NI];
  logic [31:0] res_v  [NI];
  logic [63:0] prod_v [NI];

  assign busy_v[0] = if0.busy; assign done_v[0] = if0.done; assign res_v[0] = if0.result; assign prod_v[0] = if0.product;
  assign busy_v[1] = if1.busy; assign done_v[1] = if1.done; assign res_v[1] = if1.result; assign prod_v[1] = if1.product;
  assign busy_v[2] = if2.busy; assign done_v[2] = if2.done; assign res_v[2] = if2.result; assign prod_v[2] = if2.product;
  assign busy_v[3] = if3.busy; assign done_v[3] = if3.done; assign res_v[3] = if3.result; assign prod_v[3] = if3.product;
  assign busy_v[4] = if4.busy; assign done_v[4] = if4.done; assign res_v[4] = if4.result; assign prod_v[4] = if4.product;

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  function automatic longint ext_a(MUL_OP_T o, logic [31:0] v);
    return (o == OP_MULHU) ? longint'({32'b0, v}) : longint'($signed(v));
  endfunction

  function automatic longint ext_b(MUL_OP_T o, logic [31:0] v);
    return (o == OP_MUL || o == OP_MULH) ? longint'($signed(v)) : longint'({32'b0, v});
  endfunction

  function automatic logic [63:0] ref_product(MUL_OP_T o, logic [31:0] x, logic [31:0] y);
    return 64'(ext_a(o, x) * ext_b(o, y));
  endfunction

  function automatic logic [31:0] ref_result(MUL_OP_T o, logic [63:0] p);
    return (o == OP_MUL) ? p[31:0] : p[63:32];
  endfunction

  function automatic int ref_latency(MUL_OP_T o, logic [31:0] x, logic [31:0] y, int dig, bit et);
    longint ea, eb, mag;
    int bl, n;
    ea = ext_a(o, x);
    eb = ext_b(o, y);
    if (ea == 0 || eb == 0) return 1;
    mag = (eb < 0) ? -eb : eb;
    bl = 0;
    while (mag != 0) begin
      bl++;
      mag = mag >> 1;
    end
    n = (bl + dig - 1) / dig;
    if (!et || n > 32 / dig) n = 32 / dig;
    return 1 + n;
  endfunction

  task automatic check64(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // cycle model: remaining edges to done, expected outputs, results pending for the done edge
  int          m_rem  [NI];
  bit          m_busy [NI];
  bit          m_done [NI];
  logic [31:0] m_res  [NI];
  logic [63:0] m_prod [NI];
  logic [31:0] p_res  [NI];
  logic [63:0] p_prod [NI];
  bit          prev_done;
  int          lat_m;

  initial begin
    for (int i = 0; i < NI; i++) begin
      m_rem[i] = 0; m_busy[i] = 0; m_done[i] = 0; m_res[i] = '0; m_prod[i] = '0;
    end
    for (int i = 0; i < 10; i++) hist[i] = 0;
  end

  always @(posedge clk_in) begin
    for (int i = 0; i < NI; i++) begin
      if (reset_in) begin
        m_rem[i] = 0; m_busy[i] = 0; m_done[i] = 0; m_res[i] = '0; m_prod[i] = '0;
      end else begin
        prev_done = m_done[i];
        m_done[i] = 0;
        if (m_rem[i] > 0) begin
          if (abort) begin
            m_rem[i] = 0;
            m_busy[i] = 0;
          end else begin
            m_rem[i]--;
            if (m_rem[i] == 0) begin
              m_done[i] = 1; m_res[i] = p_res[i]; m_prod[i] = p_prod[i];
            end
          end
        end else if (prev_done) begin
          m_busy[i] = 0;
        end else if (start && !abort) begin
          lat_m = ref_latency(op, a, b, dig_p[i], et_p[i]);
          if (i == 0) hist[lat_m]++;
          p_prod[i] = ref_product(op, a, b);
          p_res[i]  = ref_result(op, p_prod[i]);
          m_busy[i] = 1;
          if (lat_m == 1) begin
            m_done[i] = 1; m_res[i] = p_res[i]; m_prod[i] = p_prod[i];
          end else begin
            m_rem[i] = lat_m - 1;
          end
        end
      end
    end
    #1;
    for (int i = 0; i < NI; i++) begin
      check64($sformatf("busy[%0d]", i), 64'(busy_v[i]), 64'(m_busy[i]));
      check64($sformatf("done[%0d]", i), 64'(done_v[i]), 64'(m_done[i]));
      check64($sformatf("result[%0d]", i), 64'(res_v[i]), 64'(m_res[i]));
      check64($sformatf("product[%0d]", i), prod_v[i], m_prod[i]);
    end
  end

  task automatic wait_all_idle();
    int t;
    bit any;
    t = 0;
    do begin
      @(negedge clk_in);
      any = 0;
      for (int i = 0; i < NI; i++) any |= busy_v[i];
      t++;
    end while (any && t < 100);
    if (any) begin
      n_checks++;
      n_errors++;
      $display("FAIL idle_timeout: busy still set after %0d cycles, required idle", t);
    end
  endtask

  // exp_lat == 0 means no done pulse is expected within the window
  task automatic run_op(string name, MUL_OP_T o, logic [31:0] x, logic [31:0] y, int abort_at, int restart_at,
                        int exp_lat, logic [31:0] exp_res, logic [63:0] exp_prod);
    int lat;
    bit seen;
    wait_all_idle();
    op = o; a = x; b = y; start = 1'b1;
    lat = 0;
    seen = 0;
    while (!seen && lat < 40) begin
      @(posedge clk_in);
      lat++;
      #1;
      if (lat == 1) begin
        start = 1'b0;
        a = $urandom; b = $urandom;
      end
      if (lat == restart_at) begin
        op = OP_MUL; a = 32'd2; b = 32'd3; start = 1'b1;
      end
      if (lat == restart_at + 1) start = 1'b0;
      if (lat == abort_at - 1) abort = 1'b1;
      if (lat == abort_at) abort = 1'b0;
      if (if0.done) seen = 1;
      if (exp_lat == 0 && lat >= 14) break;
    end
    start = 1'b0;
    abort = 1'b0;
    if (exp_lat == 0) begin
      check64({name, "_no_done"}, 64'(seen), 64'd0);
      check64({name, "_busy"}, 64'(if0.busy), 64'd0);
    end else begin
      check64({name, "_latency"}, 64'(seen ? lat : -1), 64'(exp_lat));
    end
    check64({name, "_result"}, 64'(if0.result), 64'(exp_res));
    check64({name, "_product"}, if0.product, exp_prod);
  endtask

  initial begin
    reset_in = 1'b1; start = 1'b0; abort = 1'b0; op = OP_MUL; a = '0; b = '0;
    repeat (3) @(negedge clk_in);
    check64("reset_busy", 64'(if0.busy), 64'd0);
    check64("reset_done", 64'(if0.done), 64'd0);
    check64("reset_result", 64'(if0.result), 64'd0);
    check64("reset_product", if0.product, 64'd0);
    reset_in = 1'b0;

    check64("model_mulhsu", ref_product(OP_MULHSU, 32'hFFFFFFFE, 32'hFFFFFFFF), 64'hFFFFFFFE_00000002);
    check64("model_mulh_min", ref_product(OP_MULH, 32'h80000000, 32'h1), 64'hFFFFFFFF_80000000);
    check64("model_lat_dig1", 64'(ref_latency(OP_MUL, 32'd5, 32'd9, 1, 1)), 64'd5);

    run_op("mul_9x3",   OP_MUL,    32'd9,          32'd3,          0, 0, 2, 32'd27,        64'd27);
    run_op("mulh_m1",   OP_MULH,   32'hFFFFFFFF,   32'hFFFFFFFF,   0, 0, 2, 32'h0,         64'd1);
    run_op("mulhsu",    OP_MULHSU, 32'hFFFFFFFE,   32'hFFFFFFFF,   0, 0, 9, 32'hFFFFFFFE,  64'hFFFFFFFE_00000002);
    run_op("mulhu_big", OP_MULHU,  32'h80000000,   32'h80000000,   0, 0, 9, 32'h40000000,  64'h40000000_00000000);
    run_op("mul_zero",  OP_MUL,    32'd666,        32'd0,          0, 0, 1, 32'h0,         64'h0);
    run_op("mulh_min",  OP_MULH,   32'h80000000,   32'h1,          0, 0, 2, 32'hFFFFFFFF,  64'hFFFFFFFF_80000000);
    run_op("abort",     OP_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF,   4, 0, 0, 32'hFFFFFFFF,  64'hFFFFFFFF_80000000);
    run_op("restart",   OP_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF,   0, 2, 9, 32'hFFFFFFFE,  64'hFFFFFFFE_00000001);

    wait_all_idle();
    op = OP_MULHU; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; start = 1'b1;
    @(negedge clk_in);
    start = 1'b0;
    repeat (2) @(negedge clk_in);
    reset_in = 1'b1;
    @(negedge clk_in);
    reset_in = 1'b0;
    check64("midreset_busy", 64'(if0.busy), 64'd0);
    check64("midreset_result", 64'(if0.result), 64'd0);
    check64("midreset_product", if0.product, 64'd0);

    for (int k = 0; k < 1500; k++) begin
      int cls;
      wait_all_idle();
      op  = MUL_OP_T'($urandom_range(0, 3));
      cls = $urandom_range(0, 3);
      a   = (cls == 0) ? 32'h0 : (cls == 1) ? 32'($urandom_range(0, 255)) : (cls == 2) ? $urandom : 32'h80000000;
      cls = $urandom_range(0, 4);
      b   = (cls == 0) ? 32'h0 : (cls == 1) ? 32'($urandom_range(0, 255)) : (cls == 2) ? 32'hFFFFFFFF :
            (cls == 3) ? 32'h80000000 : $urandom;
      start = 1'b1;
      abort = ($urandom_range(0, 15) == 0);
      repeat ($urandom_range(1, 12)) begin
        @(negedge clk_in);
        start = ($urandom_range(0, 19) == 0);
        abort = ($urandom_range(0, 24) == 0);
        a = $urandom; b = 32'($urandom_range(0, 4095));
        op = MUL_OP_T'($urandom_range(0, 3));
      end
      @(negedge clk_in);
      start = 1'b0;
      abort = 1'b0;
    end
    wait_all_idle();

    $display("latency histogram (DIG=4): 1:%0d 2:%0d 3:%0d 4:%0d 5:%0d 6:%0d 7:%0d 8:%0d 9:%0d",
             hist[1], hist[2], hist[3], hist[4], hist[5], hist[6], hist[7], hist[8], hist[9]);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
